// File: rtl/proc_param.sv
// Multicycle processor core with DW-bit datapath, conditional relative branches,
// Z/N/C flags and a Ready handshake on every memory access.
module proc_param #(
    parameter int unsigned   DW       = 16,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    input  logic          Ready,
    output logic [DW-1:0] DOUT,
    output logic [DW-1:0] ADDR,
    output logic          W,
    output logic          Done,
    output logic [2:0]    Flags
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_B   = 3'b111;

    state_t          state_q, state_d;
    logic [DW-1:0]   regs_q [7];
    logic [DW-1:0]   regs_d [7];
    logic [DW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   g_q, g_d;
    logic [15:0]     ir_q, ir_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            w_q, w_d;
    logic [2:0]      flags_q, flags_d;

    logic [2:0]      op, rx, ry;
    logic            m;
    logic [DW-1:0]   imm_d, mvt_val, offset;
    logic [DW-1:0]   rf [8];
    logic [DW-1:0]   rx_val, ry_val, alu_b, alu_res;
    logic [DW:0]     add_full;
    logic            alu_c, cond_true, is_alu;
    logic            wr_en;
    logic [DW-1:0]   wr_val;

    assign op      = ir_q[15:13];
    assign m       = ir_q[12];
    assign rx      = ir_q[11:9];
    assign ry      = ir_q[2:0];
    assign imm_d   = {{(DW-9){1'b0}}, ir_q[8:0]};
    assign mvt_val = {ir_q[7:0], {(DW-8){1'b0}}};
    assign offset  = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);

    // Register 7 reads as the PC so every operand path sees one uniform file.
    always_comb begin
        for (int i = 0; i < 7; i++) rf[i] = regs_q[i];
        rf[7] = pc_q;
    end

    assign rx_val   = rf[rx];
    assign ry_val   = rf[ry];
    assign alu_b    = m ? imm_d : ry_val;
    assign add_full = {1'b0, a_q} + {1'b0, alu_b};

    always_comb begin
        alu_res = add_full[DW-1:0];
        alu_c   = add_full[DW];
        case (op)
            OP_SUB: begin
                alu_res = a_q - alu_b;
                alu_c   = (a_q >= alu_b);
            end
            OP_AND: begin
                alu_res = a_q & alu_b;
                alu_c   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        cond_true = 1'b0;
        case (rx)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[2];
            3'b010:  cond_true = ~flags_q[2];
            3'b011:  cond_true = ~flags_q[0];
            3'b100:  cond_true = flags_q[0];
            3'b101:  cond_true = ~flags_q[1];
            3'b110:  cond_true = flags_q[1];
            default: cond_true = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= T0;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            T0: state_d = Run ? T1 : T0;
            T1: state_d = Ready ? T2 : T1;
            T2: state_d = T3;
            T3: begin
                if (op == OP_MV || op == OP_MVT || (op == OP_B && !cond_true)) state_d = T0;
                else                                                           state_d = T4;
            end
            T4: state_d = (op == OP_LD && !Ready) ? T4 : T5;
            T5: state_d = (op == OP_ST && !Ready) ? T5 : T0;
            default: state_d = T0;
        endcase
    end

    // Output logic
    always_comb begin
        Done = 1'b0;
        if (state_q == T3)
            Done = (op == OP_MV) || (op == OP_MVT) || (op == OP_B && !cond_true);
        else if (state_q == T5)
            Done = !(op == OP_ST && !Ready);
    end

    // NOTE: every _d is defaulted to its _q before the case so no path infers a latch.
    always_comb begin
        regs_d  = regs_q;
        pc_d    = pc_q;
        a_d     = a_q;
        g_d     = g_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        w_d     = w_q;
        flags_d = flags_q;
        wr_en   = 1'b0;
        wr_val  = '0;
        unique case (state_q)
            T0: begin
                addr_d = pc_q;
                if (Run) pc_d = pc_q + 1'b1;
            end
            T2: ir_d = DIN[15:0];
            T3: begin
                if (op == OP_MV) begin
                    wr_en  = 1'b1;
                    wr_val = m ? imm_d : ry_val;
                end else if (op == OP_MVT) begin
                    wr_en  = 1'b1;
                    wr_val = mvt_val;
                end else if (is_alu) begin
                    a_d = rx_val;
                end else if (op == OP_LD || op == OP_ST) begin
                    addr_d = ry_val;
                end else if (cond_true) begin
                    a_d = pc_q;
                end
            end
            T4: begin
                if (is_alu) begin
                    g_d     = alu_res;
                    flags_d = {(alu_res == '0), alu_res[DW-1], alu_c};
                end else if (op == OP_ST) begin
                    dout_d = rx_val;
                    w_d    = 1'b1;
                end else if (op == OP_B) begin
                    g_d = a_q + offset;
                end
            end
            T5: begin
                if (is_alu) begin
                    wr_en  = 1'b1;
                    wr_val = g_q;
                end else if (op == OP_LD) begin
                    wr_en  = 1'b1;
                    wr_val = DIN;
                end else if (op == OP_ST) begin
                    if (Ready) w_d = 1'b0;
                end else if (op == OP_B) begin
                    pc_d = g_q;
                end
            end
            default: ;
        endcase
        // A write to register 7 lands in the PC, overriding any increment.
        if (wr_en) begin
            if (rx == 3'd7) pc_d = wr_val;
            for (int i = 0; i < 7; i++)
                if (rx == 3'(i)) regs_d[i] = wr_val;
        end
    end

    // NOTE: the register file is reset too, so an aborted instruction leaves nothing behind.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            regs_q  <= '{default: '0};
            pc_q    <= RESET_PC;
            a_q     <= '0;
            g_q     <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            w_q     <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            g_q     <= g_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            w_q     <= w_d;
            flags_q <= flags_d;
        end
    end

    assign ADDR  = addr_q;
    assign DOUT  = dout_q;
    assign W     = w_q;
    assign Flags = flags_q;

endmodule
